// File: rtl/paq8bto32b.sv
// Receive-side packer: reassembles 32-bit words from a sof-framed byte stream.
// Misframed bytes are dropped or resynced, and each framing error pulses err_out.

module paq8bto32b_lane (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       we_i,
  input  logic [7:0] d_i,
  output logic [7:0] q_o
);
  logic [7:0] byte_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  byte_q <= 8'h00;
    else if (we_i) byte_q <= d_i;
  end

  assign q_o = byte_q;
endmodule

module paq8bto32b #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        valid_in,
  input  logic        sof_in,
  input  logic [7:0]  data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        err_out
);
  localparam int NUM_HELD = 3;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [NUM_HELD-1:0]       we;
  logic [NUM_HELD-1:0][7:0]  part;
  logic [3:0][7:0]           bytes;
  logic [31:0]               word;
  logic [31:0]               data_q;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;
  logic                      load;

  // Bytes 0..2 are parked in lanes; byte 3 goes straight from data_in into the word.
  for (genvar k = 0; k < NUM_HELD; k++) begin : g_lane
    paq8bto32b_lane u_lane (
      .clk     (clk),
      .reset_L (reset_L),
      .we_i    (we[k]),
      .d_i     (data_in),
      .q_o     (part[k])
    );
  end

  always_comb begin
    bytes[0] = part[0];
    bytes[1] = part[1];
    bytes[2] = part[2];
    bytes[3] = data_in;
  end

  for (genvar k = 0; k < 4; k++) begin : g_place
    if (MSB_FIRST) begin : g_msb
      assign word[31-8*k -: 8] = bytes[k];
    end else begin : g_lsb
      assign word[8*k +: 8] = bytes[k];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = '0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    if (valid_in) begin
      case (state_q)
        S_IDLE: begin
          if (sof_in) begin
            we[0]   = 1'b1;
            cnt_d   = 2'd1;
            state_d = S_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          if (sof_in) begin
            // Resync: abandon the partial word but keep this byte as byte 0.
            err_d = 1'b1;
            we[0] = 1'b1;
            cnt_d = 2'd1;
          end else if (cnt_q != 2'd3) begin
            we    = 3'b001 << cnt_q;
            cnt_d = cnt_q + 2'd1;
          end else begin
            load    = 1'b1;
            valid_d = 1'b1;
            cnt_d   = 2'd0;
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      data_q  <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (load) data_q <= word;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign err_out   = err_q;
endmodule
